// File: rtl/ias_core_mc_if.sv
// ias_core_mc_if: memory req/ack bus between the IAS core (master) and the memory model (slave)
//   mem_req    master->slave  request, held until mem_ack
//   mem_we     master->slave  1 = write, 0 = read
//   mem_addr   master->slave  access address
//   mem_wdata  master->slave  write data
//   mem_rdata  slave->master  read data, valid in the ack cycle
//   mem_ack    slave->master  one-cycle acknowledge
interface ias_core_mc_if #(
    parameter int DATA_W = 40,
    parameter int ADDR_W = 12
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/ias_core_mc.sv
// ias_core_mc: multi-cycle IAS accumulator core with fetch/decode/execute FSM over a req/ack memory bus
//   clk       sole clock, rising edge
//   rst_n     asynchronous active-low reset
//   mem       ias_core_mc_if master: registered request signals, read data and ack
//   halted    core stopped
//   illegal   stopped on an undefined opcode
//   pc_o      current PC
//   ac_o      accumulator
//   mq_o      MQ register
module ias_core_mc #(
    parameter int DATA_W   = 40,
    parameter int ADDR_W   = 12,
    parameter int RESET_PC = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    ias_core_mc_if.master       mem,
    output logic                halted,
    output logic                illegal,
    output logic [ADDR_W-1:0]   pc_o,
    output logic [DATA_W-1:0]   ac_o,
    output logic [DATA_W-1:0]   mq_o
);
    localparam int H = DATA_W / 2;
    typedef enum logic [2:0] {FETCH, FETCH_W, DECODE, OPRD_W, EXEC, WRITE_W, HALT} state_t;
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d, mar_q, mar_d, addr_q, addr_d;
    logic [DATA_W-1:0]   ac_q, ac_d, mq_q, mq_d, mbr_q, mbr_d, wdata_q, wdata_d;
    logic [H-1:0]        ibr_q, ibr_d;
    logic [7:0]          ir_q, ir_d;
    logic                skip_q, skip_d, right_q, right_d, req_q, req_d, we_q, we_d;
    logic                halted_q, halted_d, illegal_q, illegal_d, adv;
    logic [H-1:0]        half;
    logic [7:0]          dop;
    logic [ADDR_W-1:0]   dadr;
    logic                mem_op, jmp;
    logic [DATA_W-1:0]   abs_m, w_a, w_b;
    logic [2*DATA_W-1:0] prod;
    // right_q marks that the op being decoded is the right half, taken from IBR
    assign half   = right_q ? ibr_q : mbr_q[DATA_W-1 -: H];
    assign dop    = half[H-1 -: 8];
    assign dadr   = half[H-9 -: ADDR_W];
    assign mem_op = dop inside {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                                8'h09, 8'h0B, 8'h12, 8'h13};
    assign jmp    = ir_q inside {8'h0D, 8'h0E} || (ir_q inside {8'h0F, 8'h10} && !ac_q[DATA_W-1]);
    assign abs_m  = mbr_q[DATA_W-1] ? -mbr_q : mbr_q;
    // low 2*DATA_W bits of the product of sign-extended operands form the signed product
    assign prod   = {{DATA_W{mq_q[DATA_W-1]}}, mq_q} * {{DATA_W{mbr_q[DATA_W-1]}}, mbr_q};
    always_comb begin
        w_a = mbr_q;
        w_b = mbr_q;
        w_a[DATA_W-9 -: ADDR_W] = ac_q[ADDR_W-1:0];
        w_b[H-9 -: ADDR_W] = ac_q[ADDR_W-1:0];
    end
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        mar_d     = mar_q;
        addr_d    = addr_q;
        ac_d      = ac_q;
        mq_d      = mq_q;
        mbr_d     = mbr_q;
        wdata_d   = wdata_q;
        ibr_d     = ibr_q;
        ir_d      = ir_q;
        skip_d    = skip_q;
        right_d   = right_q;
        req_d     = req_q;
        we_d      = we_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        adv       = 1'b0;
        case (state_q)
            FETCH: begin
                req_d   = 1'b1;
                we_d    = 1'b0;
                addr_d  = pc_q;
                state_d = FETCH_W;
            end
            FETCH_W: if (mem.mem_ack) begin
                req_d   = 1'b0;
                mbr_d   = mem.mem_rdata;
                ibr_d   = mem.mem_rdata[H-1:0];
                right_d = skip_q;
                state_d = DECODE;
            end
            DECODE: begin
                ir_d    = dop;
                mar_d   = dadr;
                req_d   = mem_op;
                we_d    = 1'b0;
                addr_d  = mem_op ? dadr : addr_q;
                state_d = mem_op ? OPRD_W : EXEC;
            end
            OPRD_W: if (mem.mem_ack) begin
                req_d   = 1'b0;
                mbr_d   = mem.mem_rdata;
                state_d = EXEC;
            end
            EXEC: begin
                adv = 1'b1;
                case (ir_q)
                    8'h01: ac_d = mbr_q;
                    8'h02: ac_d = -mbr_q;
                    8'h03: ac_d = abs_m;
                    8'h04: ac_d = -abs_m;
                    8'h05: ac_d = ac_q + mbr_q;
                    8'h06: ac_d = ac_q - mbr_q;
                    8'h07: ac_d = ac_q + abs_m;
                    8'h08: ac_d = ac_q - abs_m;
                    8'h09: mq_d = mbr_q;
                    8'h0A: ac_d = mq_q;
                    8'h0B: {ac_d, mq_d} = prod;
                    8'h14: ac_d = ac_q << 1;
                    8'h15: ac_d = {ac_q[DATA_W-1], ac_q[DATA_W-1:1]};
                    8'h12, 8'h13, 8'h21: begin
                        adv     = 1'b0;
                        req_d   = 1'b1;
                        we_d    = 1'b1;
                        addr_d  = mar_q;
                        wdata_d = ir_q == 8'h21 ? ac_q : ir_q == 8'h12 ? w_a : w_b;
                        state_d = WRITE_W;
                    end
                    8'h0D, 8'h0E, 8'h0F, 8'h10: if (jmp) begin
                        adv     = 1'b0;
                        pc_d    = mar_q;
                        skip_d  = ir_q inside {8'h0E, 8'h10};
                        state_d = FETCH;
                    end
                    8'hFF: begin
                        adv      = 1'b0;
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end
                    default: begin
                        adv       = 1'b0;
                        halted_d  = 1'b1;
                        illegal_d = 1'b1;
                        state_d   = HALT;
                    end
                endcase
            end
            WRITE_W: if (mem.mem_ack) begin
                req_d = 1'b0;
                we_d  = 1'b0;
                adv   = 1'b1;
            end
            default: ;
        endcase
        // a finished left op falls through to the right op already held in IBR
        if (adv) begin
            right_d = 1'b1;
            state_d = right_q ? FETCH : DECODE;
            pc_d    = right_q ? pc_q + ADDR_W'(1) : pc_q;
            skip_d  = right_q ? 1'b0 : skip_q;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            pc_q      <= ADDR_W'(RESET_PC);
            mar_q     <= '0;
            addr_q    <= '0;
            ac_q      <= '0;
            mq_q      <= '0;
            mbr_q     <= '0;
            wdata_q   <= '0;
            ibr_q     <= '0;
            ir_q      <= '0;
            skip_q    <= 1'b0;
            right_q   <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            mar_q     <= mar_d;
            addr_q    <= addr_d;
            ac_q      <= ac_d;
            mq_q      <= mq_d;
            mbr_q     <= mbr_d;
            wdata_q   <= wdata_d;
            ibr_q     <= ibr_d;
            ir_q      <= ir_d;
            skip_q    <= skip_d;
            right_q   <= right_d;
            req_q     <= req_d;
            we_q      <= we_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign halted        = halted_q;
    assign illegal       = illegal_q;
    assign pc_o          = pc_q;
    assign ac_o          = ac_q;
    assign mq_o          = mq_q;
endmodule

// File: tb/tb_ias_core_mc.sv
// tb_ias_core_mc: directed programs against ias_core_mc with a scoreboard of expected architectural results
module tb_ias_core_mc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic spur = 1'b0;
    logic rand_w = 1'b0;
    int   fixed_w = 0;
    int   cnt = 0;
    int   wait_n = 0;
    int   errors = 0;
    int   checks = 0;
    logic        halted, illegal;
    logic [11:0] pc;
    logic [39:0] ac, mq;
    logic [39:0] mem [0:4095];
    ias_core_mc_if #(.DATA_W(40), .ADDR_W(12)) mem_if ();
    ias_core_mc #(.DATA_W(40), .ADDR_W(12), .RESET_PC(3)) dut (
        .clk(clk), .rst_n(rst_n), .mem(mem_if), .halted(halted), .illegal(illegal),
        .pc_o(pc), .ac_o(ac), .mq_o(mq)
    );
    always #5 clk = ~clk;
    assign mem_if.mem_ack   = (mem_if.mem_req && cnt >= wait_n) || spur;
    assign mem_if.mem_rdata = mem[mem_if.mem_addr];
    always @(posedge clk) begin
        if (mem_if.mem_req && mem_if.mem_ack) begin
            if (mem_if.mem_we) mem[mem_if.mem_addr] <= mem_if.mem_wdata;
            cnt <= 0;
        end else if (mem_if.mem_req) begin
            cnt <= cnt + 1;
        end else begin
            cnt <= 0;
            wait_n <= rand_w ? int'($urandom_range(0, 3)) : fixed_w;
        end
    end
    logic        p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
    logic [11:0] p_addr = '0;
    logic [39:0] p_wd = '0;
    always @(negedge clk) begin
        if (rst_n && p_req && !p_ack && mem_if.mem_req) begin
            checks++;
            assert ({mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata} === {p_we, p_addr, p_wd})
            else begin
                errors++;
                $error("FAIL req_stable: got %h expected %h",
                       {mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata}, {p_we, p_addr, p_wd});
            end
        end
        p_req  = rst_n && mem_if.mem_req;
        p_ack  = mem_if.mem_ack;
        p_we   = mem_if.mem_we;
        p_addr = mem_if.mem_addr;
        p_wd   = mem_if.mem_wdata;
    end
    typedef struct {
        string       tag;
        int          sel;
        int          a;
        logic [39:0] exp;
    } exp_t;
    exp_t sb[$];
    function automatic logic [39:0] obs(int sel, int a);
        case (sel)
            0: return ac;
            1: return mq;
            2: return 40'(pc);
            3: return mem[a];
            4: return 40'(halted);
            5: return 40'(illegal);
            6: return 40'(mem_if.mem_req);
            7: return 40'(mem_if.mem_we);
            8: return 40'(mem_if.mem_addr);
            default: return mem_if.mem_wdata;
        endcase
    endfunction
    task automatic want(input string tag, input int sel, input int a, input logic [39:0] e);
        sb.push_back('{tag: tag, sel: sel, a: a, exp: e});
    endtask
    task automatic drain();
        exp_t        e;
        logic [39:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sel, e.a);
            checks++;
            assert (o === e.exp)
            else begin
                errors++;
                $error("FAIL %s: got %h expected %h", e.tag, o, e.exp);
            end
        end
    endtask
    function automatic logic [39:0] w(logic [7:0] lo, logic [11:0] la, logic [7:0] ro, logic [11:0] ra);
        return {lo, la, ro, ra};
    endfunction
    task automatic begin_test();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] <= '0;
        @(negedge clk);
    endtask
    task automatic run(input string tag);
        int n;
        n = 0;
        rst_n = 1'b1;
        while (!halted && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (halted === 1'b1)
        else begin
            errors++;
            $error("FAIL %s_timeout: got halted=%b expected 1 within 400 cycles", tag, halted);
        end
        repeat (3) @(negedge clk);
    endtask
    task automatic load_add();
        mem[0] <= 40'd15;
        mem[1] <= 40'd5;
        mem[3] <= w(8'h01, 12'd0, 8'h05, 12'd1);
        mem[4] <= w(8'h21, 12'd2, 8'hFF, 12'd0);
    endtask
    initial begin
        begin_test();
        want("rst_pc", 2, 0, 40'd3);
        want("rst_ac", 0, 0, 40'd0);
        want("rst_mq", 1, 0, 40'd0);
        want("rst_req", 6, 0, 40'd0);
        want("rst_we", 7, 0, 40'd0);
        want("rst_addr", 8, 0, 40'd0);
        want("rst_wdata", 9, 0, 40'd0);
        want("rst_halted", 4, 0, 40'd0);
        want("rst_illegal", 5, 0, 40'd0);
        drain();
        load_add();
        run("add");
        want("add_m2", 3, 2, 40'd20);
        want("add_ac", 0, 0, 40'd20);
        want("add_pc", 2, 0, 40'd4);
        want("add_illegal", 5, 0, 40'd0);
        want("add_noreq", 6, 0, 40'd0);
        drain();
        spur = 1'b1;
        repeat (2) @(negedge clk);
        spur = 1'b0;
        want("spur_ac", 0, 0, 40'd20);
        want("spur_pc", 2, 0, 40'd4);
        want("spur_m2", 3, 2, 40'd20);
        drain();
        begin_test();
        rand_w = 1'b1;
        load_add();
        run("add_wait");
        rand_w = 1'b0;
        want("wait_m2", 3, 2, 40'd20);
        want("wait_ac", 0, 0, 40'd20);
        drain();
        begin_test();
        mem[0] <= -40'd7;
        mem[1] <= 40'd4;
        mem[2] <= 40'd7;
        mem[3] <= w(8'h03, 12'd0, 8'h21, 12'd20);
        mem[4] <= w(8'h01, 12'd1, 8'h06, 12'd2);
        mem[5] <= w(8'h21, 12'd21, 8'h0F, 12'd8);
        mem[6] <= w(8'hFF, 12'd0, 8'hFF, 12'd0);
        mem[8] <= w(8'hFF, 12'd0, 8'hFF, 12'd0);
        run("neg");
        want("neg_abs", 3, 20, 40'd7);
        want("neg_sub_m", 3, 21, -40'd3);
        want("neg_ac", 0, 0, -40'd3);
        want("neg_jplus_pc", 2, 0, 40'd6);
        drain();
        begin_test();
        mem[3]  <= w(8'h0E, 12'd10, 8'hFF, 12'd0);
        mem[10] <= w(8'h01, 12'd12, 8'h05, 12'd13);
        mem[11] <= w(8'hFF, 12'd0, 8'hFF, 12'd0);
        mem[12] <= 40'd99;
        mem[13] <= 40'd42;
        run("jr");
        want("jr_ac", 0, 0, 40'd42);
        want("jr_pc", 2, 0, 40'd11);
        drain();
        begin_test();
        mem[3]  <= w(8'h0F, 12'd15, 8'hFF, 12'd0);
        mem[13] <= 40'd42;
        mem[15] <= w(8'h01, 12'd13, 8'hFF, 12'd0);
        run("jpl");
        want("jpl_ac", 0, 0, 40'd42);
        want("jpl_pc", 2, 0, 40'd15);
        drain();
        begin_test();
        mem[0] <= -40'd2;
        mem[1] <= 40'd3;
        mem[3] <= w(8'h09, 12'd0, 8'h0B, 12'd1);
        mem[4] <= w(8'hFF, 12'd0, 8'hFF, 12'd0);
        run("mul");
        want("mul_ac", 0, 0, {40{1'b1}});
        want("mul_mq", 1, 0, -40'd6);
        drain();
        begin_test();
        mem[0]  <= -40'd5;
        mem[3]  <= w(8'h01, 12'd0, 8'h15, 12'd0);
        mem[4]  <= w(8'h21, 12'd20, 8'h14, 12'd0);
        mem[5]  <= w(8'h21, 12'd21, 8'h13, 12'd22);
        mem[6]  <= w(8'h12, 12'd23, 8'hFF, 12'd0);
        mem[22] <= 40'h12345_6789A;
        mem[23] <= 40'h12345_6789A;
        run("shift");
        want("rsh_m20", 3, 20, -40'd3);
        want("lsh_m21", 3, 21, -40'd6);
        want("storb_m22", 3, 22, 40'h12345_67FFA);
        want("stora_m23", 3, 23, 40'h12FFA_6789A);
        want("shift_pc", 2, 0, 40'd6);
        drain();
        begin_test();
        mem[3] <= w(8'h00, 12'd0, 8'hFF, 12'd0);
        run("ill");
        want("ill_halted", 4, 0, 40'd1);
        want("ill_illegal", 5, 0, 40'd1);
        want("ill_pc", 2, 0, 40'd3);
        drain();
        begin_test();
        fixed_w = 3;
        mem[0] <= 40'd55;
        mem[3] <= w(8'h01, 12'd0, 8'hFF, 12'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 60 && !(mem_if.mem_req && !mem_if.mem_we && mem_if.mem_addr == 12'd0); i++)
            @(negedge clk);
        want("oprd_reached", 6, 0, 40'd1);
        drain();
        spur = 1'b1;
        rst_n = 1'b0;
        #1;
        want("midrst_req", 6, 0, 40'd0);
        want("midrst_pc", 2, 0, 40'd3);
        want("midrst_ac", 0, 0, 40'd0);
        want("midrst_halted", 4, 0, 40'd0);
        drain();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        run("restart");
        fixed_w = 0;
        want("restart_ac", 0, 0, 40'd55);
        want("restart_pc", 2, 0, 40'd3);
        want("restart_illegal", 5, 0, 40'd0);
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
